// File: rtl/wallace_operand_feeder.sv
// Operand feeder for the six-operand 8-bit Wallace tree: collects six beats, bit-slices them
// to the tree, captures the sum and returns it. Optional sum cross-check: WALLACE_SELF_CHECK_EN.
module wallace_operand_feeder #(
    parameter int OP_W  = 8,
    parameter int N_OPS = 6,
    parameter int SUM_W = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       in_data,
    output logic [OP_W*N_OPS-1:0] tree_x,
    input  logic [SUM_W-1:0]      tree_s,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SUM_W-1:0]      out_sum,
`ifdef WALLACE_SELF_CHECK_EN
    output logic                  chk_err,
`endif
    output logic                  busy
);

    // Handshake: a beat transfers on a rising edge where valid && ready are both high;
    // valid never depends on ready, and out_sum holds while out_valid && !out_ready.

    localparam int CNT_W = $clog2(N_OPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_OPS - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [OP_W-1:0]    ops_q [N_OPS];
    logic [OP_W-1:0]    ops_d [N_OPS];
    logic [SUM_W-1:0]   out_sum_q, out_sum_d;
    logic               chk_err_d;

`ifdef WALLACE_SELF_CHECK_EN
    logic               chk_err_q;
    logic [SUM_W-1:0]   beh_sum;

    always_comb begin
        beh_sum = '0;
        for (int j = 0; j < N_OPS; j++) begin
            beh_sum = beh_sum + SUM_W'(ops_q[j]);
        end
    end

    assign chk_err = chk_err_q;
`endif

    // Pure rewiring into the tree's bit-sliced order: bit N_OPS*i+j is bit i of operand j.
    always_comb begin
        tree_x = '0;
        for (int i = 0; i < OP_W; i++) begin
            for (int j = 0; j < N_OPS; j++) begin
                tree_x[N_OPS*i + j] = ops_q[j][i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ops_d     = ops_q;
        out_sum_d = out_sum_q;
        chk_err_d = 1'b0;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    ops_d[count_q] = in_data;
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = SETTLE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            SETTLE: begin
                out_sum_d = tree_s;
                state_d   = HOLD;
`ifdef WALLACE_SELF_CHECK_EN
                chk_err_d = (beh_sum != tree_s);
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    for (int j = 0; j < N_OPS; j++) begin
                        ops_d[j] = '0;
                    end
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            count_q   <= '0;
            out_sum_q <= '0;
            for (int j = 0; j < N_OPS; j++) begin
                ops_q[j] <= '0;
            end
`ifdef WALLACE_SELF_CHECK_EN
            chk_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            out_sum_q <= out_sum_d;
            for (int j = 0; j < N_OPS; j++) begin
                ops_q[j] <= ops_d[j];
            end
`ifdef WALLACE_SELF_CHECK_EN
            chk_err_q <= chk_err_d;
`endif
        end
    end

`ifndef WALLACE_SELF_CHECK_EN
    logic unused_chk;
    assign unused_chk = chk_err_d;
`endif

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = out_sum_q;
    assign busy      = (state_q != COLLECT) || (count_q != '0);

endmodule

// File: tb/tb_wallace_operand_feeder.sv
// Directed bench for wallace_operand_feeder with a behavioural tree model on tree_x/tree_s.
module tb_wallace_operand_feeder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [47:0] tree_x;
    logic [10:0] tree_s;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_sum;
    logic        busy;
    logic        flip_lsb;
`ifdef WALLACE_SELF_CHECK_EN
    logic        chk_err;
`endif

    int errors;
    int checks;

    wallace_operand_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tree_x    (tree_x),
        .tree_s    (tree_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef WALLACE_SELF_CHECK_EN
        .chk_err   (chk_err),
`endif
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // tree model: un-slice tree_x and add the six operands
    always_comb begin
        logic [7:0] op;
        tree_s = '0;
        for (int j = 0; j < 6; j++) begin
            op = '0;
            for (int i = 0; i < 8; i++) op[i] = tree_x[6*i + j];
            tree_s = tree_s + 11'(op);
        end
        tree_s = tree_s ^ {10'd0, flip_lsb};
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // drive one beat; caller and return point are 1 time unit after a rising edge
    task automatic beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flip_lsb  = 1'b0;
        #12;
        check("rst_in_ready", 48'(in_ready), 48'd1);
        check("rst_out_valid", 48'(out_valid), 48'd0);
        check("rst_out_sum", 48'(out_sum), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_tree_x", tree_x, 48'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full scale
        for (int k = 0; k < 6; k++) beat(8'hFF);
        check("fs_settle_tree_x", tree_x, 48'hFFFF_FFFF_FFFF);
        check("fs_settle_in_ready", 48'(in_ready), 48'd0);
        check("fs_settle_out_valid", 48'(out_valid), 48'd0);
        check("fs_settle_busy", 48'(busy), 48'd1);
        idle();
        check("fs_out_valid", 48'(out_valid), 48'd1);
        check("fs_out_sum", 48'(out_sum), 48'h5FA);
`ifdef WALLACE_SELF_CHECK_EN
        check("fs_chk_err", 48'(chk_err), 48'd0);
`endif
        handshake();
        check("fs_post_out_valid", 48'(out_valid), 48'd0);
        check("fs_post_tree_x", tree_x, 48'd0);
        check("fs_post_busy", 48'(busy), 48'd0);

        // layout
        beat(8'h01);
        for (int k = 0; k < 4; k++) beat(8'h00);
        beat(8'h80);
        check("lay_tree_x", tree_x, 48'h8000_0000_0001);
        idle();
        check("lay_out_sum", 48'(out_sum), 48'd129);
        handshake();

        // frame with a two-cycle gap
        beat(8'd1); beat(8'd2); beat(8'd3);
        idle(); idle();
        check("gap_tree_x", tree_x, 48'h185);
        check("gap_busy", 48'(busy), 48'd1);
        check("gap_in_ready", 48'(in_ready), 48'd1);
        beat(8'd4); beat(8'd5); beat(8'd6);
        check("gap_settle_in_ready", 48'(in_ready), 48'd0);
        idle();
        check("gap_out_valid", 48'(out_valid), 48'd1);
        check("gap_out_sum", 48'(out_sum), 48'd21);

        // backpressure with a pending operand
        in_valid = 1'b1;
        in_data  = 8'h33;
        for (int k = 0; k < 5; k++) begin
            idle();
            check("bp_out_valid", 48'(out_valid), 48'd1);
            check("bp_out_sum", 48'(out_sum), 48'd21);
            check("bp_in_ready", 48'(in_ready), 48'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_hs_out_valid", 48'(out_valid), 48'd0);
        check("bp_hs_tree_x", tree_x, 48'd0);
        check("bp_hs_in_ready", 48'(in_ready), 48'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        check("bp_first_tree_x", tree_x, 48'h0000_4100_0041);
        check("bp_first_busy", 48'(busy), 48'd1);
        for (int k = 0; k < 5; k++) beat(8'h00);
        idle();
        check("bp_out_sum2", 48'(out_sum), 48'd51);
        handshake();

        // asynchronous reset mid-frame
        beat(8'd7); beat(8'd8); beat(8'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_tree_x", tree_x, 48'd0);
        check("ar_busy", 48'(busy), 48'd0);
        check("ar_in_ready", 48'(in_ready), 48'd1);
        check("ar_out_sum", 48'(out_sum), 48'd0);
        check("ar_out_valid", 48'(out_valid), 48'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(8'd10); beat(8'd20); beat(8'd30);
        beat(8'd40); beat(8'd50); beat(8'd60);
        idle();
        check("ar_frame_out_valid", 48'(out_valid), 48'd1);
        check("ar_frame_out_sum", 48'(out_sum), 48'd210);
        handshake();

`ifdef WALLACE_SELF_CHECK_EN
        // faulty tree: chk_err pulses once on HOLD entry
        flip_lsb = 1'b1;
        beat(8'd1); beat(8'd2); beat(8'd3);
        beat(8'd4); beat(8'd5); beat(8'd6);
        check("sc_settle_chk_err", 48'(chk_err), 48'd0);
        idle();
        check("sc_hold_chk_err", 48'(chk_err), 48'd1);
        check("sc_out_sum", 48'(out_sum), 48'd20);
        idle();
        check("sc_pulse_end", 48'(chk_err), 48'd0);
        handshake();
        flip_lsb = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
